// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU opcodes,
// status bit positions and the arbiter state encoding.
package alu_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int STAT_W = 3;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam int ST_Z = 0;
    localparam int ST_V = 1;
    localparam int ST_N = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 16-bit ALU. Purely combinational; Z and N describe the result,
// while V always reports the signed overflow of A-B whatever the opcode.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [1:0]        op_i,
    output logic [DATA_W-1:0] y_o,
    output logic [STAT_W-1:0] status_o
);

    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] y;

    assign diff = a_i - b_i;

    // Operation select and status flag generation
    always_comb begin
        y = '0;
        case (op_i)
            ALU_ADD:  y = a_i + b_i;
            ALU_SUB:  y = diff;
            ALU_AND:  y = a_i & b_i;
            default:  y = ~b_i;
        endcase
        status_o       = '0;
        status_o[ST_Z] = (y == '0);
        status_o[ST_V] = (a_i[DATA_W-1] ^ b_i[DATA_W-1]) & (diff[DATA_W-1] ^ a_i[DATA_W-1]);
        status_o[ST_N] = y[DATA_W-1];
    end

    assign y_o = y;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. Each
// operation runs IDLE (accept) -> EXEC (compute from latched operands)
// -> RESP (hold result until the owner takes it).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid0,
    output logic              req_ready0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [1:0]        op0,
    input  logic              req_valid1,
    output logic              req_ready1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [1:0]        op1,
    output logic              resp_valid0,
    input  logic              resp_ready0,
    output logic              resp_valid1,
    input  logic              resp_ready1,
    output logic [DATA_W-1:0] resp_out,
    output logic [STAT_W-1:0] resp_status,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                id_q, id_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [STAT_W-1:0]   status_q, status_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                grant_any;
    logic                grant_id;
    logic [DATA_W-1:0]   alu_y;
    logic [STAT_W-1:0]   alu_status;

    // The ALU only ever sees the latched operands
    alu_arbiter_alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .y_o      (alu_y),
        .status_o (alu_status)
    );

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        grant_any = req_valid0 | req_valid1;
        if (req_valid0 && req_valid1) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req_valid1;
        end
    end

    // Next-state, latch enables and handshake outputs
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        res_d        = res_q;
        status_d     = status_q;
        count_d      = count_q;
        req_ready0   = 1'b0;
        req_ready1   = 1'b0;
        resp_valid0  = 1'b0;
        resp_valid1  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_ready0   = ~grant_id;
                    req_ready1   = grant_id;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    a_d          = grant_id ? a1  : a0;
                    b_d          = grant_id ? b1  : b0;
                    op_d         = grant_id ? op1 : op0;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                res_d    = alu_y;
                status_d = alu_status;
                state_d  = RESP;
            end
            RESP: begin
                resp_valid0 = ~id_q;
                resp_valid1 = id_q;
                if (id_q ? resp_ready1 : resp_ready0) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            res_q        <= '0;
            status_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            res_q        <= res_d;
            status_q     <= status_d;
            count_q      <= count_d;
        end
    end

    assign resp_out    = res_q;
    assign resp_status = status_q;
    assign busy        = (state_q != IDLE);
    assign op_count    = count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table-driven single operations,
// hand-written multi-cycle sequences and a randomized run against a
// transaction-level reference model.
module tb_alu_arbiter;

    localparam int CW = 4;

    logic        clk;
    logic        reset_n;
    logic        req_valid0, req_ready0, req_valid1, req_ready1;
    logic [15:0] a0, b0, a1, b1;
    logic [1:0]  op0, op1;
    logic        resp_valid0, resp_ready0, resp_valid1, resp_ready1;
    logic [15:0] resp_out;
    logic [2:0]  resp_status;
    logic        busy;
    logic [CW-1:0] op_count;

    int n_pass;
    int n_total;
    int m_count;
    logic m_last;

    typedef struct packed {
        logic        rid;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] y;
        logic [2:0]  st;
    } vec_t;

    vec_t vecs [9];

    alu_arbiter #(.CNT_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid0  (req_valid0),
        .req_ready0  (req_ready0),
        .a0          (a0),
        .b0          (b0),
        .op0         (op0),
        .req_valid1  (req_valid1),
        .req_ready1  (req_ready1),
        .a1          (a1),
        .b1          (b1),
        .op1         (op1),
        .resp_valid0 (resp_valid0),
        .resp_ready0 (resp_ready0),
        .resp_valid1 (resp_valid1),
        .resp_ready1 (resp_ready1),
        .resp_out    (resp_out),
        .resp_status (resp_status),
        .busy        (busy),
        .op_count    (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference ALU from the arithmetic definition of each operation
    function automatic logic [18:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] op);
        logic [15:0] y;
        logic [2:0]  st;
        int          d;
        case (op)
            2'd0:    y = a + b;
            2'd1:    y = a - b;
            2'd2:    y = a & b;
            default: y = ~b;
        endcase
        d     = int'($signed(a)) - int'($signed(b));
        st[0] = (y == 16'h0000);
        st[1] = (d > 32767) || (d < -32768);
        st[2] = y[15];
        return {st, y};
    endfunction

    function automatic logic rdy(input logic id);
        return id ? req_ready1 : req_ready0;
    endfunction

    function automatic logic rvld(input logic id);
        return id ? resp_valid1 : resp_valid0;
    endfunction

    task automatic clear_inputs();
        req_valid0 = 0; req_valid1 = 0; resp_ready0 = 0; resp_ready1 = 0;
        a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_count = 0;
        m_last  = 1'b1;
    endtask

    task automatic drive_req(input logic id, input logic v, input logic [15:0] a,
                             input logic [15:0] b, input logic [1:0] op);
        if (id) begin req_valid1 = v; a1 = a; b1 = b; op1 = op; end
        else    begin req_valid0 = v; a0 = a; b0 = b; op0 = op; end
    endtask

    task automatic set_rready(input logic id, input logic v);
        if (id) resp_ready1 = v;
        else    resp_ready0 = v;
    endtask

    // One complete isolated transaction; starts and ends in the first half of a cycle
    task automatic do_op(input vec_t v);
        drive_req(v.rid, 1'b1, v.a, v.b, v.op);
        #1;
        check("tbl_req_ready_own", 32'(rdy(v.rid)), 32'd1);
        check("tbl_req_ready_other", 32'(rdy(~v.rid)), 32'd0);
        @(negedge clk);
        req_valid0 = 0; req_valid1 = 0;
        a0 = ~a0; b0 = ~b0; op0 = ~op0; a1 = ~a1; b1 = ~b1; op1 = ~op1;
        #1;
        check("tbl_busy_exec", 32'(busy), 32'd1);
        check("tbl_resp_valid_exec", 32'(rvld(v.rid)), 32'd0);
        @(negedge clk);
        #1;
        check("tbl_resp_valid", 32'(rvld(v.rid)), 32'd1);
        check("tbl_resp_valid_other", 32'(rvld(~v.rid)), 32'd0);
        check("tbl_resp_out", 32'(resp_out), 32'(v.y));
        check("tbl_resp_status", 32'(resp_status), 32'(v.st));
        set_rready(v.rid, 1'b1);
        @(negedge clk);
        set_rready(v.rid, 1'b0);
        m_count++;
        m_last = v.rid;
        #1;
        check("tbl_busy_done", 32'(busy), 32'd0);
        check("tbl_op_count", 32'(op_count), 32'(m_count % 16));
        $display("txn req%0d op=%0d a=%04h b=%04h -> out=%04h st=%03b cnt=%0d",
                 v.rid, v.op, v.a, v.b, resp_out, resp_status, op_count);
    endtask

    initial begin
        logic        exp_own;
        logic        pend;
        logic        own;
        logic        g;
        logic        do_grant;
        logic        in_resp;
        int          acc_cyc;
        logic [18:0] exp_r;

        n_pass  = 0;
        n_total = 0;
        reset_n = 1'b0;
        clear_inputs();
        m_count = 0;
        m_last  = 1'b1;

        vecs[0] = '{1'b0, 16'h0003, 16'h0004, 2'b00, 16'h0007, 3'b000};
        vecs[1] = '{1'b0, 16'h0005, 16'h0005, 2'b01, 16'h0000, 3'b001};
        vecs[2] = '{1'b1, 16'h8000, 16'h0001, 2'b01, 16'h7FFF, 3'b010};
        vecs[3] = '{1'b1, 16'h8000, 16'h0001, 2'b10, 16'h0000, 3'b011};
        vecs[4] = '{1'b1, 16'h0000, 16'h0000, 2'b11, 16'hFFFF, 3'b100};
        vecs[5] = '{1'b0, 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 3'b001};
        vecs[6] = '{1'b0, 16'h7FFF, 16'h0001, 2'b00, 16'h8000, 3'b100};
        vecs[7] = '{1'b1, 16'h7FFF, 16'hFFFF, 2'b01, 16'h8000, 3'b110};
        vecs[8] = '{1'b0, 16'hF0F0, 16'hFF00, 2'b10, 16'hF000, 3'b100};

        // Outputs while held in reset
        #1;
        check("rst_req_ready0", 32'(req_ready0), 32'd0);
        check("rst_req_ready1", 32'(req_ready1), 32'd0);
        check("rst_resp_valid0", 32'(resp_valid0), 32'd0);
        check("rst_resp_valid1", 32'(resp_valid1), 32'd0);
        check("rst_resp_out", 32'(resp_out), 32'd0);
        check("rst_resp_status", 32'(resp_status), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);

        // Table: 18 operations, so op_count (4 bits here) wraps through 0
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 9; i++) do_op(vecs[i]);
        end

        // Round robin with both requesters always valid
        do_reset();
        drive_req(1'b0, 1'b1, 16'h0010, 16'h0001, 2'b00);
        drive_req(1'b1, 1'b1, 16'h0010, 16'h0001, 2'b01);
        resp_ready0 = 1; resp_ready1 = 1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_own = ((k / 3) % 2) == 1;
            check("rr_ready0", 32'(req_ready0), 32'((k % 3 == 0) && !exp_own));
            check("rr_ready1", 32'(req_ready1), 32'((k % 3 == 0) && exp_own));
            if (k % 3 == 2) begin
                check("rr_resp_valid", 32'(rvld(exp_own)), 32'd1);
                check("rr_resp_out", 32'(resp_out), exp_own ? 32'h000F : 32'h0011);
            end
        end
        $display("txn round-robin both-valid sequence 0,1,0");

        // Requester 1 alone three times in a row
        do_reset();
        drive_req(1'b1, 1'b1, 16'h0002, 16'h0003, 2'b00);
        resp_ready1 = 1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check("solo1_ready1", 32'(req_ready1), 32'(k % 3 == 0));
            check("solo1_ready0", 32'(req_ready0), 32'd0);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        check("solo1_op_count", 32'(op_count), 32'd3);
        $display("txn requester1 granted three times");

        // Backpressure: result held for 5 cycles while requester 1 waits
        do_reset();
        drive_req(1'b0, 1'b1, 16'h8000, 16'h0001, 2'b00);
        #1;
        check("bp_ready0", 32'(req_ready0), 32'd1);
        @(negedge clk);
        req_valid0 = 0;
        drive_req(1'b1, 1'b1, 16'h0005, 16'h0003, 2'b00);
        resp_ready1 = 1;
        #1;
        check("bp_ready1_exec", 32'(req_ready1), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("bp_resp_valid0", 32'(resp_valid0), 32'd1);
            check("bp_resp_valid1", 32'(resp_valid1), 32'd0);
            check("bp_resp_out", 32'(resp_out), 32'h8001);
            check("bp_resp_status", 32'(resp_status), 32'b110);
            check("bp_ready1_hold", 32'(req_ready1), 32'd0);
        end
        resp_ready0 = 1;
        @(negedge clk);
        resp_ready0 = 0;
        #1;
        check("bp_resp_valid0_drop", 32'(resp_valid0), 32'd0);
        check("bp_ready1_grant", 32'(req_ready1), 32'd1);
        @(negedge clk);
        req_valid1 = 0;
        @(negedge clk);
        #1;
        check("bp_resp1_out", 32'(resp_out), 32'h0008);
        check("bp_resp1_valid", 32'(resp_valid1), 32'd1);
        @(negedge clk);
        #1;
        check("bp_op_count", 32'(op_count), 32'd2);
        $display("txn backpressure req0 out=8001 then req1 out=0008");

        // Asynchronous reset during EXEC drops the operation
        clear_inputs();
        drive_req(1'b0, 1'b1, 16'h0001, 16'h0001, 2'b00);
        #1;
        check("mid_ready0", 32'(req_ready0), 32'd1);
        @(negedge clk);
        req_valid0 = 0;
        reset_n = 0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_resp_out", 32'(resp_out), 32'd0);
        check("mid_resp_status", 32'(resp_status), 32'd0);
        check("mid_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        reset_n = 1;
        resp_ready0 = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("mid_no_resp0", 32'(resp_valid0), 32'd0);
            check("mid_no_resp1", 32'(resp_valid1), 32'd0);
            check("mid_idle", 32'(busy), 32'd0);
        end
        $display("txn reset during exec dropped");

        // Randomized traffic against the transaction-level model
        do_reset();
        pend    = 0;
        own     = 0;
        acc_cyc = 0;
        exp_r   = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid0  = ($urandom_range(0, 1) == 1);
            req_valid1  = ($urandom_range(0, 1) == 1);
            resp_ready0 = ($urandom_range(0, 2) != 0);
            resp_ready1 = ($urandom_range(0, 2) != 0);
            a0 = 16'($urandom); b0 = 16'($urandom); op0 = 2'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom); op1 = 2'($urandom);
            #1;
            do_grant = !pend && (req_valid0 || req_valid1);
            g = (req_valid0 && req_valid1) ? !m_last : req_valid1;
            in_resp = pend && (cyc >= acc_cyc + 2);
            check("rnd_ready0", 32'(req_ready0), 32'(do_grant && !g));
            check("rnd_ready1", 32'(req_ready1), 32'(do_grant && g));
            check("rnd_busy", 32'(busy), 32'(pend));
            check("rnd_resp_valid0", 32'(resp_valid0), 32'(in_resp && !own));
            check("rnd_resp_valid1", 32'(resp_valid1), 32'(in_resp && own));
            check("rnd_op_count", 32'(op_count), 32'(m_count % 16));
            if (in_resp) begin
                check("rnd_resp_out", 32'(resp_out), 32'(exp_r[15:0]));
                check("rnd_resp_status", 32'(resp_status), 32'(exp_r[18:16]));
            end
            if (do_grant) begin
                pend    = 1;
                acc_cyc = cyc;
                own     = g;
                m_last  = g;
                exp_r   = g ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
            end else if (in_resp && (own ? resp_ready1 : resp_ready0)) begin
                pend = 0;
                m_count++;
                $display("txn rnd req%0d out=%04h st=%03b cnt=%0d",
                         own, exp_r[15:0], exp_r[18:16], m_count % 16);
            end
            @(negedge clk);
        end

        clear_inputs();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 16-bit ALU (Z/V/N status) between two requesters using a round-robin arbiter.
- Each requester has its own valid/ready request channel and valid/ready response channel.
- Operands and opcode are latched before execution; result and status are latched before response. The ALU is never driven by live requester inputs.
- Sits between the two datapath front-ends and the single shared ALU instance.

Parameters:
- CNT_W, 16, width of the completed-operation counter op_count.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid0  in  1  requester 0 has an operation.
- req_ready0  out  1  requester 0 operation accepted this cycle.
- a0, b0  in  16  requester 0 operands.
- op0  in  2  requester 0 ALUop: 00 add, 01 sub, 10 and, 11 not-B.
- req_valid1, req_ready1, a1, b1, op1: same roles for requester 1.
- resp_valid0  out  1  result for requester 0 available.
- resp_ready0  in  1  requester 0 takes the result.
- resp_valid1, resp_ready1: same roles for requester 1.
- resp_out  out  16  latched ALU result (shared bus; qualify with resp_valid0/1).
- resp_status  out  3  latched status: bit0 Z, bit1 V, bit2 N.
- busy  out  1  state is not IDLE.
- op_count  out  CNT_W  completed operations, wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; req_ready0/1=0; resp_valid0/1=0; resp_out=0; resp_status=0; busy=0; op_count=0; last_grant=1 (requester 0 wins first tie). Any in-flight operation is dropped with no response.
- State IDLE:
  - Grant selection: if exactly one req_valid is high, grant it. If both are high, grant the requester not equal to last_grant.
  - req_ready of the granted requester is combinationally high in this cycle only. The other req_ready is 0.
  - On grant, latch a/b/op and the requester id; last_grant <= id; next state EXEC.
  - No valid request: stay in IDLE.
- State EXEC (one cycle):
  - ALU inputs come from the latched operands.
  - resp_out <= ALU out; resp_status <= ALU status. Status is passed through unchanged, so V is always the signed overflow of A−B regardless of op, as the ALU computes it.
  - Next state RESP.
- State RESP:
  - resp_valid[id]=1 and the other resp_valid=0. resp_out and resp_status stay stable.
  - When resp_ready[id]=1: op_count += 1 (wraps), next state IDLE.
  - Otherwise hold indefinitely. While in RESP, both req_ready are 0.
- Timing:
  - Latency: request accepted in cycle T; resp_valid rises in cycle T+2.
  - Minimum issue interval is 3 cycles. No back-to-back issue from RESP.
- Request channel rules:
  - req_valid may drop before acceptance. A requester is granted only if valid in the IDLE cycle.
  - Operands are sampled only at acceptance; changes afterwards have no effect.
- resp_ready asserted while resp_valid is low is ignored.
- busy = (state != IDLE).
- Illegal state encodings return to IDLE.

Decomposition:
- Shared package:
  - ALUop constants: ALU_ADD=00, ALU_SUB=01, ALU_AND=10, ALU_NOTB=11.
  - Status bit indices: ST_Z=0, ST_V=1, ST_N=2.
  - State encodings: IDLE, EXEC, RESP.
- One sub-module: the existing ALU, instantiated once with latched operands. The arbiter logic lives in alu_arbiter itself.

Test Plan:
- Single add: reset, req_valid0=1, a0=0x0003, b0=0x0004, op0=00 → req_ready0 high in cycle T; resp_valid0 high at T+2 with resp_out=0x0007, resp_status=000. resp_ready0=1 → op_count=1, busy=0 next cycle.
- Status/V quirk: req1 AND, a1=0x8000, b1=0x0001 → resp_valid1 with resp_out=0x0000, resp_status=011 (Z=1, V=1 from A−B overflow). req1 NOT-B, b1=0x0000 → resp_out=0xFFFF, status=100.
- Round robin:
  - Both valid right after reset → requester 0 granted first, then requester 1, then 0 again.
  - Requester 1 alone valid three times in a row → granted every time.
- Backpressure: resp_ready0 held low for 5 cycles in RESP → resp_valid0, resp_out and resp_status stable; req_ready1 stays 0 despite req_valid1=1; resp_ready0=1 → requester 1 granted in the following IDLE cycle.
- Operand stability: change a0 the cycle after acceptance → response reflects the originally accepted value.
- Reset mid-operation: drop reset_n during EXEC → all outputs zero immediately (asynchronous); no stale response after release; op_count=0. Force op_count to 2^CNT_W−1, complete one op → op_count wraps to 0.
